// File: rtl/arbitro_memoria_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arbitro_memoria_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        EXEC   = 2'd1,
        ESPERA = 2'd2,
        FIM    = 2'd3
    } estado_t;

    localparam logic PORTA_CPU = 1'b0;
    localparam logic PORTA_IO  = 1'b1;

    localparam int MEM_WORDS_PADRAO = 50;
    localparam int READ_LAT_PADRAO  = 1;

endpackage

// File: rtl/arbitro_rr.sv
// Two-way round-robin picker: the requester other than the last winner wins ties.
// Latency: purely combinational.
// Backpressure: none; the parent decides when a pick is accepted and keeps 'ultimo'.
module arbitro_rr
    import arbitro_memoria_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ultimo,
    output logic valido,
    output logic vencedor
);

    // Single requester wins outright; on a tie, the port not served last wins
    always_comb begin
        valido = req0 | req1;
        if (req0 && req1) begin
            vencedor = ~ultimo;
        end else if (req1) begin
            vencedor = PORTA_IO;
        end else begin
            vencedor = PORTA_CPU;
        end
    end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Round-robin req/ack controller for the data memory (CPU on port 0, I/O on port 1).
// Latency: write/error ack 2 cycles after req is sampled, read ack 2+READ_LAT cycles.
// Backpressure: one transaction in flight; other requests wait while ocupado is high.
module arbitro_memoria_dados
    import arbitro_memoria_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = MEM_WORDS_PADRAO,
    parameter int READ_LAT  = READ_LAT_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] endereco0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] endereco1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic [DATA_W-1:0] saida,
    output logic              erro,
    output logic              ocupado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_controle_escrita,
    input  logic [DATA_W-1:0] mem_saida
);

    localparam logic [ADDR_W-1:0] LIMITE  = ADDR_W'(MEM_WORDS);
    localparam logic [2:0]        LAT_INI = 3'(READ_LAT);

    estado_t r_estado;
    estado_t w_prox;

    logic r_ultimo;
    logic r_porta;
    logic r_we;
    logic r_fora;
    logic [2:0] r_cont;

    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_saida;
    logic              r_erro;
    logic              r_ocupado;
    logic [ADDR_W-1:0] r_mem_end;
    logic [DATA_W-1:0] r_mem_dat;
    logic              r_mem_we;

    logic              w_valido;
    logic              w_vencedor;
    logic              w_we_venc;
    logic [ADDR_W-1:0] w_end_venc;
    logic [DATA_W-1:0] w_dat_venc;
    logic              w_fora_venc;

    logic              w_ack0_prox;
    logic              w_ack1_prox;
    logic [DATA_W-1:0] w_saida_prox;
    logic              w_erro_prox;
    logic              w_ocupado_prox;
    logic [ADDR_W-1:0] w_mem_end_prox;
    logic [DATA_W-1:0] w_mem_dat_prox;
    logic              w_mem_we_prox;

    arbitro_rr u_rr (
        .req0     (req0),
        .req1     (req1),
        .ultimo   (r_ultimo),
        .valido   (w_valido),
        .vencedor (w_vencedor)
    );

    // Mux the winning requester's command; the range test uses the full address width
    always_comb begin
        w_we_venc   = (w_vencedor == PORTA_IO) ? we1       : we0;
        w_end_venc  = (w_vencedor == PORTA_IO) ? endereco1 : endereco0;
        w_dat_venc  = (w_vencedor == PORTA_IO) ? data1     : data0;
        w_fora_venc = (w_end_venc >= LIMITE);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Next-state logic: writes and out-of-range accesses skip the read wait
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO: if (w_valido) w_prox = EXEC;
            EXEC:   w_prox = (r_we || r_fora) ? FIM : ESPERA;
            ESPERA: if (r_cont == 3'd1) w_prox = FIM;
            FIM:    w_prox = OCIOSO;
            default: w_prox = OCIOSO;
        endcase
    end

    // Output logic: next values of the registered outputs, so every pin is a flop
    always_comb begin
        w_ack0_prox    = 1'b0;
        w_ack1_prox    = 1'b0;
        w_saida_prox   = '0;
        w_erro_prox    = 1'b0;
        w_ocupado_prox = (w_prox != OCIOSO);
        w_mem_end_prox = r_mem_end;
        w_mem_dat_prox = r_mem_dat;
        w_mem_we_prox  = 1'b0;
        // The memory address/data registers double as the latch for the winner's command
        if (r_estado == OCIOSO && w_valido) begin
            w_mem_end_prox = w_end_venc;
            w_mem_dat_prox = w_dat_venc;
            w_mem_we_prox  = w_we_venc && !w_fora_venc;
        end
        if (w_prox == FIM) begin
            w_ack0_prox  = (r_porta == PORTA_CPU);
            w_ack1_prox  = (r_porta == PORTA_IO);
            w_erro_prox  = r_fora;
            w_saida_prox = (r_estado == ESPERA) ? mem_saida : '0;
        end
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_saida   <= '0;
            r_erro    <= 1'b0;
            r_ocupado <= 1'b0;
            r_mem_end <= '0;
            r_mem_dat <= '0;
            r_mem_we  <= 1'b0;
        end else begin
            r_ack0    <= w_ack0_prox;
            r_ack1    <= w_ack1_prox;
            r_saida   <= w_saida_prox;
            r_erro    <= w_erro_prox;
            r_ocupado <= w_ocupado_prox;
            r_mem_end <= w_mem_end_prox;
            r_mem_dat <= w_mem_dat_prox;
            r_mem_we  <= w_mem_we_prox;
        end
    end

    // Grant bookkeeping and read-latency counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ultimo <= PORTA_IO;
            r_porta  <= PORTA_CPU;
            r_we     <= 1'b0;
            r_fora   <= 1'b0;
            r_cont   <= '0;
        end else begin
            if (r_estado == OCIOSO && w_valido) begin
                r_ultimo <= w_vencedor;
                r_porta  <= w_vencedor;
                r_we     <= w_we_venc;
                r_fora   <= w_fora_venc;
            end
            if (r_estado == EXEC) begin
                r_cont <= LAT_INI;
            end else if (r_estado == ESPERA) begin
                r_cont <= r_cont - 3'd1;
            end
        end
    end

    assign ack0                 = r_ack0;
    assign ack1                 = r_ack1;
    assign saida                = r_saida;
    assign erro                 = r_erro;
    assign ocupado              = r_ocupado;
    assign mem_endereco         = r_mem_end;
    assign mem_data             = r_mem_dat;
    assign mem_controle_escrita = r_mem_we;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
module tb_arbitro_memoria_dados;

    typedef struct {
        int          porta;
        logic [31:0] saida;
        logic        erro;
        int          ciclo;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    // instance A: READ_LAT = 1
    logic        req0, we0, req1, we1, ack0, ack1, erro, ocupado, mem_we;
    logic [31:0] endereco0, data0, endereco1, data1, saida, mem_endereco, mem_data, mem_saida;
    // instance B: READ_LAT = 3
    logic        req0_b, we0_b, req1_b, we1_b, ack0_b, ack1_b, erro_b, ocupado_b, mem_we_b;
    logic [31:0] endereco0_b, data0_b, endereco1_b, data1_b, saida_b, mem_endereco_b, mem_data_b, mem_saida_b;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    arbitro_memoria_dados #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(50), .READ_LAT(1)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .endereco0(endereco0), .data0(data0), .ack0(ack0),
        .req1(req1), .we1(we1), .endereco1(endereco1), .data1(data1), .ack1(ack1),
        .saida(saida), .erro(erro), .ocupado(ocupado),
        .mem_endereco(mem_endereco), .mem_data(mem_data),
        .mem_controle_escrita(mem_we), .mem_saida(mem_saida)
    );

    arbitro_memoria_dados #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(50), .READ_LAT(3)) dut_b (
        .clock(clock), .reset(reset),
        .req0(req0_b), .we0(we0_b), .endereco0(endereco0_b), .data0(data0_b), .ack0(ack0_b),
        .req1(req1_b), .we1(we1_b), .endereco1(endereco1_b), .data1(data1_b), .ack1(ack1_b),
        .saida(saida_b), .erro(erro_b), .ocupado(ocupado_b),
        .mem_endereco(mem_endereco_b), .mem_data(mem_data_b),
        .mem_controle_escrita(mem_we_b), .mem_saida(mem_saida_b)
    );

    // Memory models: synchronous write, registered read through a delay line.
    // Word i starts out holding i * 0x01010101.
    logic [31:0] mem_a [0:49];
    logic [31:0] mem_b [0:49];
    logic [31:0] pipe_a [1:4];
    logic [31:0] pipe_b [1:4];
    logic ini_a = 1'b0;
    logic ini_b = 1'b0;

    always @(posedge clock) begin
        if (!ini_a) begin
            for (int i = 0; i < 50; i++) mem_a[i] <= i * 32'h01010101;
            ini_a <= 1'b1;
        end else if (mem_we && mem_endereco < 50) begin
            mem_a[mem_endereco[5:0]] <= mem_data;
        end
        pipe_a[1] <= (mem_endereco < 50) ? mem_a[mem_endereco[5:0]] : 32'h0;
        for (int k = 2; k <= 4; k++) pipe_a[k] <= pipe_a[k-1];
    end

    always @(posedge clock) begin
        if (!ini_b) begin
            for (int i = 0; i < 50; i++) mem_b[i] <= i * 32'h01010101;
            ini_b <= 1'b1;
        end else if (mem_we_b && mem_endereco_b < 50) begin
            mem_b[mem_endereco_b[5:0]] <= mem_data_b;
        end
        pipe_b[1] <= (mem_endereco_b < 50) ? mem_b[mem_endereco_b[5:0]] : 32'h0;
        for (int k = 2; k <= 4; k++) pipe_b[k] <= pipe_b[k-1];
    end

    assign mem_saida   = pipe_a[1];
    assign mem_saida_b = pipe_b[3];

    function automatic void chk(string nome, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nome, got, exp, cyc);
        end
    endfunction

    function automatic void esperar(int inst, int p, logic [31:0] s, logic er, int ciclo);
        exp_t e;
        e.porta = p; e.saida = s; e.erro = er; e.ciclo = ciclo;
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endfunction

    function automatic logic ack_de(int inst, int p);
        if (inst == 0) return (p == 0) ? ack0 : ack1;
        return (p == 0) ? ack0_b : ack1_b;
    endfunction

    task automatic set_req(input int inst, input int p, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (inst == 0 && p == 0)      begin req0 = r;   we0 = w;   endereco0 = a;   data0 = d;   end
        else if (inst == 0)           begin req1 = r;   we1 = w;   endereco1 = a;   data1 = d;   end
        else if (p == 0)              begin req0_b = r; we0_b = w; endereco0_b = a; data0_b = d; end
        else                          begin req1_b = r; we1_b = w; endereco1_b = a; data1_b = d; end
    endtask

    // Raise a request (optionally pushing its expected response), wait for ack, drop req.
    task automatic issue(input int inst, input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] es, input logic ee,
                         input int lat, input bit empilhar);
        int n;
        if (empilhar) esperar(inst, p, es, ee, cyc + lat);
        set_req(inst, p, 1'b1, w, a, d);
        n = 0;
        while (!ack_de(inst, p) && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("ack_within_budget", 32'(n < 40), 32'd1);
        set_req(inst, p, 1'b0, w, a, d);
    endtask

    function automatic void verificar_ack(int inst, int porta, logic [31:0] s, logic er, logic ambos);
        exp_t e;
        if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: inst %0d port %0d at cycle %0d, none required", inst, porta, cyc);
            return;
        end
        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
        chk("ack_port",   32'(porta), 32'(e.porta));
        chk("ack_saida",  s, e.saida);
        chk("ack_erro",   32'(er), 32'(e.erro));
        chk("ack_cycle",  32'(cyc), 32'(e.ciclo));
        chk("ack_single", 32'(ambos), 32'd0);
    endfunction

    // Monitor: every ack is matched against the head of the scoreboard queue
    always @(negedge clock) begin
        if (ack0 || ack1)     verificar_ack(0, ack1 ? 1 : 0, saida, erro, ack0 && ack1);
        if (ack0_b || ack1_b) verificar_ack(1, ack1_b ? 1 : 0, saida_b, erro_b, ack0_b && ack1_b);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1;
        set_req(0, 0, 0, 0, 0, 0); set_req(0, 1, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0); set_req(1, 1, 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // reset state
        chk("rst_ack0", 32'(ack0), 0);
        chk("rst_ack1", 32'(ack1), 0);
        chk("rst_saida", saida, 0);
        chk("rst_erro", 32'(erro), 0);
        chk("rst_ocupado", 32'(ocupado), 0);
        chk("rst_mem_endereco", mem_endereco, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_we", 32'(mem_we), 0);

        // tie from reset: port 0 first, then alternation over four writes
        @(negedge clock);
        c = cyc;
        esperar(0, 0, 0, 0, c + 2);
        esperar(0, 1, 0, 0, c + 5);
        esperar(0, 0, 0, 0, c + 8);
        esperar(0, 1, 0, 0, c + 11);
        fork
            begin
                issue(0, 0, 1, 10, 32'hA0, 0, 0, 0, 0);
                repeat (2) @(negedge clock);
                issue(0, 0, 1, 12, 32'hA2, 0, 0, 0, 0);
            end
            begin
                issue(0, 1, 1, 11, 32'hA1, 0, 0, 0, 0);
                repeat (2) @(negedge clock);
                issue(0, 1, 1, 13, 32'hA3, 0, 0, 0, 0);
            end
        join

        // CPU write: strobe only in the EXEC cycle
        @(negedge clock);
        fork
            issue(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 2, 1);
            begin
                @(negedge clock);
                chk("exec_mem_we", 32'(mem_we), 1);
                chk("exec_mem_endereco", mem_endereco, 5);
                chk("exec_mem_data", mem_data, 32'hDEADBEEF);
                chk("exec_ocupado", 32'(ocupado), 1);
                @(negedge clock);
                chk("fim_mem_we", 32'(mem_we), 0);
            end
        join

        // I/O read-back of the word just written
        @(negedge clock);
        issue(0, 1, 0, 5, 0, 32'hDEADBEEF, 0, 3, 1);

        // out-of-range write: no strobe, erro set, memory untouched
        @(negedge clock);
        fork
            issue(0, 0, 1, 50, 32'h55555555, 0, 1, 2, 1);
            begin
                @(negedge clock);
                chk("oor_no_strobe", 32'(mem_we), 0);
            end
        join
        @(negedge clock);
        issue(0, 0, 0, 49, 0, 32'h31313131, 0, 3, 1);

        // out-of-range read with a high address bit set
        @(negedge clock);
        issue(0, 1, 0, 32'h80000005, 0, 0, 1, 2, 1);

        // word written during the arbitration sequence
        @(negedge clock);
        issue(0, 0, 0, 12, 0, 32'hA2, 0, 3, 1);

        // reset in the EXEC cycle of a write
        @(negedge clock);
        set_req(0, 0, 1, 1, 7, 32'h77777777);
        @(negedge clock);
        chk("pre_reset_mem_we", 32'(mem_we), 1);
        reset = 1'b1;
        set_req(0, 0, 0, 1, 7, 32'h77777777);
        @(negedge clock);
        chk("reset_mem_we", 32'(mem_we), 0);
        chk("reset_ocupado", 32'(ocupado), 0);
        chk("reset_ack0", 32'(ack0), 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        issue(0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 3, 1);

        // READ_LAT = 3 instance: write 9, read 3 (address held), read 9
        @(negedge clock);
        issue(1, 1, 1, 9, 32'hCAFEF00D, 0, 0, 2, 1);
        @(negedge clock);
        fork
            issue(1, 0, 0, 3, 0, 32'h03030303, 0, 5, 1);
            begin
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clock);
                    chk("lat3_mem_endereco", mem_endereco_b, 3);
                end
            end
        join
        @(negedge clock);
        issue(1, 0, 0, 9, 0, 32'hCAFEF00D, 0, 5, 1);

        repeat (4) @(negedge clock);
        chk("queue0_drained", 32'(q0.size()), 0);
        chk("queue1_drained", 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
